// File: rtl/mixer_mc.sv
// N-channel stereo mixer: per-channel 4-bit L/R gains, one MAC per clock,
// latched PCM per sample period and a first-order sigma-delta 1-bit DAC per side.
module mixer_mc #(
    parameter int unsigned CHANNELS   = 6,
    parameter int unsigned DW         = 8,
    parameter int unsigned GW         = 4,
    parameter int unsigned SAMPLE_DIV = 256
) (
    input  logic                                   clk28,
    input  logic                                   rst_n,
    input  logic [CHANNELS*DW-1:0]                 ch_data,
    input  logic [CHANNELS*GW-1:0]                 gain_l,
    input  logic [CHANNELS*GW-1:0]                 gain_r,
    input  logic                                   mute,
    output logic [DW+GW+$clog2(CHANNELS)-1:0]      pcm_l,
    output logic [DW+GW+$clog2(CHANNELS)-1:0]      pcm_r,
    output logic                                   sample_stb,
    output logic                                   dac_l,
    output logic                                   dac_r
);

    localparam int unsigned SW  = DW + GW + $clog2(CHANNELS);
    localparam int unsigned PW  = DW + GW;
    localparam int unsigned IW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned PCW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    // The sequence SNAP, ACC x N, LATCH has to fit inside one mix period.
    if (SAMPLE_DIV < CHANNELS + 2) begin : g_div_check
        $error("mixer_mc: SAMPLE_DIV must be at least CHANNELS+2");
    end

    typedef enum logic [1:0] {
        ST_SNAP  = 2'd0,
        ST_ACC   = 2'd1,
        ST_LATCH = 2'd2,
        ST_IDLE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [PCW-1:0]  pc;
    logic [IW-1:0]   idx;
    logic [DW-1:0]   snap_data [CHANNELS];
    logic [GW-1:0]   snap_gl   [CHANNELS];
    logic [GW-1:0]   snap_gr   [CHANNELS];
    logic            snap_mute;
    logic [SW-1:0]   sum_l;
    logic [SW-1:0]   sum_r;
    logic [SW:0]     acc_l;
    logic [SW:0]     acc_r;

    logic            pc_wrap_c;
    logic            last_ch_c;
    logic            snap_en_c;
    logic            acc_en_c;
    logic            latch_en_c;
    logic [PW-1:0]   prod_l_c;
    logic [PW-1:0]   prod_r_c;

    assign pc_wrap_c = (pc == PCW'(SAMPLE_DIV - 1));
    assign last_ch_c = (idx == IW'(CHANNELS - 1));
    assign prod_l_c  = PW'(snap_data[idx]) * PW'(snap_gl[idx]);
    assign prod_r_c  = PW'(snap_data[idx]) * PW'(snap_gr[idx]);

    // State register
    always_ff @(posedge clk28) begin
        if (!rst_n) begin
            state <= ST_SNAP;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath strobes
    always_comb begin
        state_nxt  = state;
        snap_en_c  = 1'b0;
        acc_en_c   = 1'b0;
        latch_en_c = 1'b0;
        case (state)
            ST_SNAP: begin
                snap_en_c = 1'b1;
                state_nxt = ST_ACC;
            end
            ST_ACC: begin
                acc_en_c = 1'b1;
                if (last_ch_c) begin
                    state_nxt = ST_LATCH;
                end
            end
            ST_LATCH: begin
                latch_en_c = 1'b1;
                // When LATCH lands on the last count of the period, skip IDLE.
                state_nxt  = pc_wrap_c ? ST_SNAP : ST_IDLE;
            end
            ST_IDLE: begin
                if (pc_wrap_c) begin
                    state_nxt = ST_SNAP;
                end
            end
            default: state_nxt = ST_SNAP;
        endcase
    end

    // Period counter, input snapshot, MAC and PCM latch
    always_ff @(posedge clk28) begin
        if (!rst_n) begin
            pc         <= '0;
            idx        <= '0;
            sum_l      <= '0;
            sum_r      <= '0;
            pcm_l      <= '0;
            pcm_r      <= '0;
            sample_stb <= 1'b0;
            snap_mute  <= 1'b0;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                snap_data[i] <= '0;
                snap_gl[i]   <= '0;
                snap_gr[i]   <= '0;
            end
        end else begin
            pc         <= pc_wrap_c ? '0 : pc + PCW'(1);
            sample_stb <= latch_en_c;
            if (snap_en_c) begin
                for (int i = 0; i < int'(CHANNELS); i++) begin
                    snap_data[i] <= ch_data[i*DW +: DW];
                    snap_gl[i]   <= gain_l[i*GW +: GW];
                    snap_gr[i]   <= gain_r[i*GW +: GW];
                end
                snap_mute <= mute;
                sum_l     <= '0;
                sum_r     <= '0;
                idx       <= '0;
            end
            if (acc_en_c) begin
                sum_l <= sum_l + SW'(prod_l_c);
                sum_r <= sum_r + SW'(prod_r_c);
                idx   <= idx + IW'(1);
            end
            if (latch_en_c) begin
                pcm_l <= snap_mute ? '0 : sum_l;
                pcm_r <= snap_mute ? '0 : sum_r;
            end
        end
    end

    // Sigma-delta: the carry out of an SW-bit phase accumulator is the bitstream
    always_ff @(posedge clk28) begin
        if (!rst_n) begin
            acc_l <= '0;
            acc_r <= '0;
        end else begin
            acc_l <= {1'b0, acc_l[SW-1:0]} + {1'b0, pcm_l};
            acc_r <= {1'b0, acc_r[SW-1:0]} + {1'b0, pcm_r};
        end
    end

    assign dac_l = acc_l[SW];
    assign dac_r = acc_r[SW];

endmodule
